psum_scratch_buf: RTL
=====================

# psum_scratch_buf

Multi-bank partial-sum scratch buffer for the MNIST streamline datapath. It is the parametrised successor to the single 8-bit temp store and sits between the MAC array and the activation/requant stage. It holds `NUM_BANKS` independent banks of signed partial sums. Each write either stores or read-modify-write accumulates, with same-address hazard forwarding. A per-bank sequential clear sweep replaces the one-cycle array wipe.

## Interface
- `NUM_BANKS`, 4, number of independent banks
- `DEPTH`, 128, words per bank (MAC count)
- `DATA_WIDTH`, 16, signed partial-sum width
- `ADDR_WIDTH`, `$clog2(DEPTH)`, word address width
- `BANK_WIDTH`, `$clog2(NUM_BANKS)` (minimum 1), bank select width
- `clk_i` in 1: single clock, all logic on rising edge
- `rst_i` in 1: reset, asynchronous, active-high
- `wr_en_i` in 1: write request
- `wr_mode_i` in 1: 0 = store, 1 = accumulate (`mem += wr_data_i`)
- `wr_bank_i` in `BANK_WIDTH`: write bank
- `wr_addr_i` in `ADDR_WIDTH`: write address
- `wr_data_i` in `DATA_WIDTH`: signed write operand
- `rd_en_i` in 1: read request
- `rd_bank_i` in `BANK_WIDTH`: read bank
- `rd_addr_i` in `ADDR_WIDTH`: read address
- `rd_data_o` out `DATA_WIDTH`: read data, registered
- `rd_valid_o` out 1: `rd_data_o` valid this cycle (1-cycle pulse per read)
- `clear_i` in 1: start clear of `clear_bank_i`
- `clear_bank_i` in `BANK_WIDTH`: bank to clear
- `busy_o` out 1: clear sweep in progress
- `ovf_o` out 1: sticky saturation flag

## Operation
- FSM states:
  - IDLE: `clear_i` accepted → CLEAR.
  - CLEAR: sweep counter runs 0..DEPTH-1, writing zero to `clear_bank_i` (latched at acceptance), one word per cycle. → IDLE after word DEPTH-1.
- While `busy_o` is high, `wr_en_i`, `rd_en_i` and `clear_i` are ignored: no write, no `rd_valid_o`.
- Write pipeline:
  - Stage 1 (accept cycle N): latch bank, addr, data, mode; read old word.
  - Stage 2 (N+1): compute and commit (store: data; accumulate: old + data).
- Forwarding:
  - An accumulate in stage 1 that targets the same bank/addr as the stage-2 commit uses the stage-2 result, not the memory value.
  - A read accepted at cycle M sees every write accepted at cycle < M, with a bypass from stage 2.
  - A write accepted in the same cycle M is not visible to that read.
- Read and write ports are independent; both may be active in one cycle.
- Bank index ≥ `NUM_BANKS` (non-power-of-2 counts): request ignored, no `rd_valid_o`.
- Accumulate arithmetic: sign-extend both operands to `DATA_WIDTH+1`, add, then resolve per Configuration.
- `clear_i` acceptance also clears `ovf_o`.
- Reset mid-clear aborts the sweep (→ IDLE) and flushes the write pipeline.
- Memory contents are NOT reset; software clears each bank before first use.

## Timing
- Reset values: `rd_data_o` = 0, `rd_valid_o` = 0, `busy_o` = 0, `ovf_o` = 0, FSM = IDLE, pipeline empty.
- Read latency is 1 cycle: request at M gives `rd_valid_o`/`rd_data_o` at M+1. `rd_data_o` holds its last value when no read is in flight.
- Write commit occurs 1 cycle after accept. Back-to-back accumulates to one address at full rate are correct.
- Clear:
  - `clear_i` at cycle C → `busy_o` high from C+1 for exactly DEPTH cycles.
  - First request accepted at C+DEPTH+1.
  - A stage-2 commit in flight at C completes at C+1, before the sweep reaches it.

## Configuration
- `PSUM_BUF_SAT_EN` defined:
  - Accumulate saturates to `2^(DATA_WIDTH-1)-1` / `-2^(DATA_WIDTH-1)`.
  - `ovf_o` sets on any clamp and stays set until reset or `clear_i`.
- Not defined: accumulate wraps two's complement; `ovf_o` is tied 0.
- Store mode is never saturated.

## Structure
- `psum_buf_pkg`: write-mode constants (`WR_STORE`, `WR_ACC`), FSM state enum (IDLE, CLEAR), saturation min/max functions of `DATA_WIDTH`.
- Sub-module `psum_bank_ram`: simple dual-port RAM (1 write, 1 synchronous read), `DEPTH`×`DATA_WIDTH`, instantiated `NUM_BANKS` times by generate.
- Top level holds the FSM, sweep counter, write pipeline, forwarding and read-mux logic.

## Test plan
- Clear bank 1 → busy 128 cycles. Store 5 at (1,3), read (1,3) → `rd_valid_o` next cycle, data 5.
- Accumulate +2, +3, −1 to (0,7) on consecutive cycles after clear. Read the cycle after the last commit → 4 (exercises forwarding).
- Read (2,9) in the same cycle as a store of 11 to (2,9) → returns old value. Read again the next cycle → 11.
- With `PSUM_BUF_SAT_EN`, `DATA_WIDTH`=16: store 32760, accumulate +100 → read 32767, `ovf_o`=1. Then `clear_i` → `ovf_o`=0. Without the macro → −32676, `ovf_o`=0.
- During busy: `wr_en_i`/`rd_en_i` to bank 0 are ignored (no `rd_valid_o`, data unchanged). Assert `rst_i` at sweep word 40 → `busy_o`=0 and `rd_data_o`=0 immediately (asynchronous).
- `NUM_BANKS`=3: write to bank 3 is ignored; a read of bank 3 produces no `rd_valid_o`.

Source files
------------

// File: rtl/psum_buf_pkg.sv
// Shared definitions for the partial-sum scratch buffer.
//   WR_STORE / WR_ACC : write-mode encodings for wr_mode_i
//   psum_state_e      : clear-sweep FSM states
//   sat_max / sat_min : signed saturation limits for a given data width
package psum_buf_pkg;

    localparam logic WR_STORE = 1'b0;
    localparam logic WR_ACC   = 1'b1;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StClear = 1'b1
    } psum_state_e;

    function automatic int sat_max(input int unsigned width);
        return (1 <<< (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned width);
        return -(1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/psum_bank_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// A read that hits the word being written in the same cycle returns the old word.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request; rdata_o updates on the following cycle
//   rdata_o          : registered read data (holds while re_i is low)
module psum_bank_ram #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/psum_scratch_buf.sv
// Multi-bank partial-sum scratch buffer with store / accumulate writes.
// Two-stage write pipeline (accept + read old word, then compute + commit) with
// same-address forwarding into both the next accumulate and concurrent reads.
// A per-bank clear sweeps one word per cycle while busy_o is high.
// Optional feature macro: PSUM_BUF_SAT_EN (saturating accumulate + sticky ovf_o).
//   clk_i, rst_i (async, active-high)
//   wr_en_i/wr_mode_i/wr_bank_i/wr_addr_i/wr_data_i : write request
//   rd_en_i/rd_bank_i/rd_addr_i                     : read request
//   rd_data_o/rd_valid_o                            : read response, 1-cycle latency
//   clear_i/clear_bank_i                            : start bank clear
//   busy_o                                          : clear sweep running
//   ovf_o                                           : sticky saturation flag
module psum_scratch_buf
    import psum_buf_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  wr_mode_i,
    input  logic [BANK_WIDTH-1:0] wr_bank_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [BANK_WIDTH-1:0] rd_bank_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  clear_i,
    input  logic [BANK_WIDTH-1:0] clear_bank_i,
    output logic                  busy_o,
    output logic                  ovf_o
);

    localparam int unsigned BankSlots = 2 ** BANK_WIDTH;

    psum_state_e           state_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] sweep_cnt_q;
    logic [BANK_WIDTH-1:0] clr_bank_q;

    logic                  s2_valid_q, s2_mode_q, s2_fwd_q;
    logic [BANK_WIDTH-1:0] s2_bank_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_fwd_data_q;

    logic                  rd_valid_q, rd_fwd_q;
    logic [BANK_WIDTH-1:0] rd_bank_q;
    logic [DATA_WIDTH-1:0] rd_fwd_data_q, rd_hold_q;

    logic [BankSlots-1:0]  bank_exists;
    logic                  wr_ok, rd_ok, clr_ok;
    logic [DATA_WIDTH-1:0] rd_rdata  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rmw_rdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] old_word, acc_word, s2_result, rd_word;
    logic [DATA_WIDTH:0]   sum_ext;

    // Out-of-range bank indices (non-power-of-2 NUM_BANKS) are dropped.
    for (genvar s = 0; s < BankSlots; s++) begin : g_exists
        assign bank_exists[s] = (s < NUM_BANKS);
    end

    assign wr_ok  = !busy_q && wr_en_i && bank_exists[wr_bank_i];
    assign rd_ok  = !busy_q && rd_en_i && bank_exists[rd_bank_i];
    assign clr_ok = !busy_q && clear_i && bank_exists[clear_bank_i];

    // Stage 2: old word comes from the forward register when the previous
    // commit hit the same word, since the RAM read happened before that commit.
    always_comb begin
        old_word = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (s2_bank_q == BANK_WIDTH'(b)) old_word = rmw_rdata[b];
        end
        if (s2_fwd_q) old_word = s2_fwd_data_q;
        sum_ext = {old_word[DATA_WIDTH-1], old_word} + {s2_data_q[DATA_WIDTH-1], s2_data_q};
    end

`ifdef PSUM_BUF_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SatMax = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SatMin = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic s2_clamp;
    logic ovf_q;

    // Top two bits of the extended sum disagree exactly when the result overflowed.
    assign s2_clamp = (s2_mode_q == WR_ACC) && (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]);
    assign acc_word = !s2_clamp ? sum_ext[DATA_WIDTH-1:0] :
                      (sum_ext[DATA_WIDTH] ? SatMin : SatMax);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (clr_ok) begin
            ovf_q <= 1'b0;
        end else if (s2_valid_q && s2_clamp) begin
            ovf_q <= 1'b1;
        end
    end
    assign ovf_o = ovf_q;
`else
    assign acc_word = sum_ext[DATA_WIDTH-1:0];
    assign ovf_o    = 1'b0;
`endif

    assign s2_result = (s2_mode_q == WR_ACC) ? acc_word : s2_data_q;

    // Two RAM copies per bank, written identically, so user reads and the
    // read-modify-write old-word read never contend for one read port.
    // The sweep owns the write port of the bank it clears; a commit dropped
    // there would be zeroed by the sweep anyway.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  sweep_hit, commit_hit;
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;

        assign sweep_hit  = busy_q && (clr_bank_q == BANK_WIDTH'(b));
        assign commit_hit = s2_valid_q && (s2_bank_q == BANK_WIDTH'(b));
        assign waddr      = sweep_hit ? sweep_cnt_q : s2_addr_q;
        assign wdata      = sweep_hit ? '0 : s2_result;

        psum_bank_ram #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rd_ram (
            .clk_i   (clk_i),
            .we_i    (sweep_hit || commit_hit),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (rd_ok && (rd_bank_i == BANK_WIDTH'(b))),
            .raddr_i (rd_addr_i),
            .rdata_o (rd_rdata[b])
        );

        psum_bank_ram #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rmw_ram (
            .clk_i   (clk_i),
            .we_i    (sweep_hit || commit_hit),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (wr_ok && (wr_bank_i == BANK_WIDTH'(b))),
            .raddr_i (wr_addr_i),
            .rdata_o (rmw_rdata[b])
        );
    end

    // Clear-sweep FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            sweep_cnt_q <= '0;
            clr_bank_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr_ok) begin
                        state_q     <= StClear;
                        busy_q      <= 1'b1;
                        sweep_cnt_q <= '0;
                        clr_bank_q  <= clear_bank_i;
                    end
                end
                StClear: begin
                    sweep_cnt_q <= sweep_cnt_q + ADDR_WIDTH'(1);
                    if (sweep_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    // Write pipeline and read-side bypass registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q    <= 1'b0;
            s2_mode_q     <= WR_STORE;
            s2_bank_q     <= '0;
            s2_addr_q     <= '0;
            s2_data_q     <= '0;
            s2_fwd_q      <= 1'b0;
            s2_fwd_data_q <= '0;
            rd_valid_q    <= 1'b0;
            rd_bank_q     <= '0;
            rd_fwd_q      <= 1'b0;
            rd_fwd_data_q <= '0;
            rd_hold_q     <= '0;
        end else begin
            s2_valid_q <= wr_ok;
            if (wr_ok) begin
                s2_mode_q     <= wr_mode_i;
                s2_bank_q     <= wr_bank_i;
                s2_addr_q     <= wr_addr_i;
                s2_data_q     <= wr_data_i;
                s2_fwd_q      <= s2_valid_q && (s2_bank_q == wr_bank_i) &&
                                 (s2_addr_q == wr_addr_i);
                s2_fwd_data_q <= s2_result;
            end
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_bank_q     <= rd_bank_i;
                rd_fwd_q      <= s2_valid_q && (s2_bank_q == rd_bank_i) &&
                                 (s2_addr_q == rd_addr_i);
                rd_fwd_data_q <= s2_result;
            end
            if (rd_valid_q) begin
                rd_hold_q <= rd_data_o;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (rd_bank_q == BANK_WIDTH'(b)) rd_word = rd_rdata[b];
        end
        rd_data_o = rd_hold_q;
        if (rd_valid_q) rd_data_o = rd_fwd_q ? rd_fwd_data_q : rd_word;
    end

    assign rd_valid_o = rd_valid_q;

endmodule
